// File: rtl/amo_unit_mh.sv
// RISC-V A-extension atomic unit: LR/SC and AMO read-modify-write sequencing
// over a req/ack memory port, with one timed reservation slot per hart.
module amo_unit_mh #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned NUM_HARTS     = 2,
  parameter int unsigned RSV_GRAN_LOG2 = 2,
  parameter int unsigned RSV_TIMEOUT   = 64,
  localparam int unsigned HW           = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [HW-1:0]   req_hart_i,
  input  logic [3:0]      req_op_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_rs2_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_ack_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            snoop_we_i,
  input  logic [HW-1:0]   snoop_hart_i,
  input  logic [XLEN-1:0] snoop_addr_i,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_data_o,
  output logic            rsp_err_o
);

  localparam int unsigned OFF = $clog2(XLEN / 8);
  localparam int unsigned GW  = XLEN - RSV_GRAN_LOG2;
  localparam int unsigned CW  = $clog2(RSV_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RSV_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RSP} state_t;
  typedef enum logic [3:0] {
    OP_LR = 4'd0, OP_SC, OP_SWAP, OP_ADD, OP_XOR, OP_AND,
    OP_OR, OP_MIN, OP_MAX, OP_MINU, OP_MAXU
  } op_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hart_q;
  logic [3:0]      op_q;
  logic [XLEN-1:0] addr_q, rs2_q, old_q, rsp_data_q, amo_res;
  logic            rsp_err_q;

  logic            accept, req_err, sc_pass;
  logic [GW-1:0]   req_gran, snoop_gran, gran_q;

  logic [NUM_HARTS-1:0] rsv_valid, snoop_kill, rsv_set, rsv_clr;
  logic [GW-1:0]        rsv_gran [NUM_HARTS];
  logic [CW-1:0]        rsv_cnt  [NUM_HARTS];

  logic unused_snoop_low;

  assign req_ready_o      = (state_q == S_IDLE) & ~rst;
  assign accept           = req_valid_i & req_ready_o;
  assign req_err          = (req_op_i > 4'd10) | (req_addr_i[OFF-1:0] != '0);
  assign req_gran         = req_addr_i[XLEN-1:RSV_GRAN_LOG2];
  assign snoop_gran       = snoop_addr_i[XLEN-1:RSV_GRAN_LOG2];
  assign gran_q           = addr_q[XLEN-1:RSV_GRAN_LOG2];
  assign unused_snoop_low = ^snoop_addr_i[RSV_GRAN_LOG2-1:0];

  // SC lookup already accounts for a snoop landing in the accept cycle.
  always_comb begin
    sc_pass    = 1'b0;
    snoop_kill = '0;
    rsv_set    = '0;
    rsv_clr    = '0;
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      snoop_kill[h] = snoop_we_i & (snoop_hart_i != HW'(h)) & (rsv_gran[h] == snoop_gran);
      rsv_set[h]    = (state_q == S_RD) & mem_ack_i & (op_q == OP_LR) & (hart_q == HW'(h));
      rsv_clr[h]    = snoop_kill[h]
                    | (accept & ~req_err & (req_op_i == OP_SC) & (req_hart_i == HW'(h)))
                    | ((state_q == S_WR) & mem_ack_i & (hart_q != HW'(h)) & (rsv_gran[h] == gran_q));
      if (req_hart_i == HW'(h))
        sc_pass = rsv_valid[h] & (rsv_gran[h] == req_gran) & ~snoop_kill[h];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                 state_d = S_RSP;
          else if (req_op_i == OP_SC)  state_d = sc_pass ? S_WR : S_RSP;
          else                         state_d = S_RD;
        end
      end
      S_RD:    if (mem_ack_i) state_d = (op_q == OP_LR) ? S_RSP : S_WR;
      S_WR:    if (mem_ack_i) state_d = S_RSP;
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    amo_res = rs2_q;
    case (op_q)
      OP_ADD:  amo_res = old_q + rs2_q;
      OP_XOR:  amo_res = old_q ^ rs2_q;
      OP_AND:  amo_res = old_q & rs2_q;
      OP_OR:   amo_res = old_q | rs2_q;
      OP_MIN:  amo_res = ($signed(old_q) < $signed(rs2_q)) ? old_q : rs2_q;
      OP_MAX:  amo_res = ($signed(old_q) > $signed(rs2_q)) ? old_q : rs2_q;
      OP_MINU: amo_res = (old_q < rs2_q) ? old_q : rs2_q;
      OP_MAXU: amo_res = (old_q > rs2_q) ? old_q : rs2_q;
      default: amo_res = rs2_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hart_q     <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      rs2_q      <= '0;
      old_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        hart_q     <= req_hart_i;
        op_q       <= req_op_i;
        addr_q     <= req_addr_i;
        rs2_q      <= req_rs2_i;
        rsp_err_q  <= req_err;
        rsp_data_q <= (!req_err && (req_op_i == OP_SC) && !sc_pass) ? XLEN'(1) : '0;
      end
      if ((state_q == S_RD) && mem_ack_i) begin
        old_q      <= mem_rdata_i;
        rsp_data_q <= mem_rdata_i;
      end
      if ((state_q == S_WR) && mem_ack_i)
        rsp_data_q <= (op_q == OP_SC) ? '0 : old_q;
      if (state_q == S_RSP) begin
        rsp_data_q <= '0;
        rsp_err_q  <= 1'b0;
      end
    end
  end

  // LR set beats any same-cycle clear; expiry fires on the edge the count would hit RSV_TIMEOUT.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsv_valid <= '0;
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        rsv_gran[h] <= '0;
        rsv_cnt[h]  <= '0;
      end
    end else begin
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        if (rsv_set[h]) begin
          rsv_valid[h] <= 1'b1;
          rsv_gran[h]  <= gran_q;
          rsv_cnt[h]   <= '0;
        end else if (rsv_clr[h] | (rsv_valid[h] & (rsv_cnt[h] == CNT_LAST))) begin
          rsv_valid[h] <= 1'b0;
          rsv_cnt[h]   <= '0;
        end else if (rsv_valid[h]) begin
          rsv_cnt[h]   <= rsv_cnt[h] + CW'(1);
        end
      end
    end
  end

  assign mem_req_o   = (state_q == S_RD) | (state_q == S_WR);
  assign mem_we_o    = (state_q == S_WR);
  assign mem_addr_o  = mem_req_o ? addr_q : '0;
  assign mem_wdata_o = mem_we_o ? amo_res : '0;
  assign rsp_valid_o = (state_q == S_RSP);
  assign rsp_data_o  = rsp_valid_o ? rsp_data_q : '0;
  assign rsp_err_o   = rsp_valid_o & rsp_err_q;

endmodule

// File: tb/tb_amo_unit_mh.sv
// Directed bench for amo_unit_mh: scoreboarded responses, inline memory
// responder with programmable ack delay, immediate-assertion checks.
module tb_amo_unit_mh;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NH   = 2;
  localparam int unsigned GRAN = 2;
  localparam int unsigned TMO  = 16;
  localparam int unsigned HW   = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid_i, req_ready_o;
  logic [HW-1:0]   req_hart_i;
  logic [3:0]      req_op_i;
  logic [XLEN-1:0] req_addr_i, req_rs2_i;
  logic            mem_req_o, mem_we_o, mem_ack_i;
  logic [XLEN-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic            snoop_we_i;
  logic [HW-1:0]   snoop_hart_i;
  logic [XLEN-1:0] snoop_addr_i;
  logic            rsp_valid_o, rsp_err_o;
  logic [XLEN-1:0] rsp_data_o;

  amo_unit_mh #(.XLEN(XLEN), .NUM_HARTS(NH), .RSV_GRAN_LOG2(GRAN), .RSV_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_hart_i(req_hart_i),
    .req_op_i(req_op_i), .req_addr_i(req_addr_i), .req_rs2_i(req_rs2_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .snoop_we_i(snoop_we_i), .snoop_hart_i(snoop_hart_i), .snoop_addr_i(snoop_addr_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            err;
  } rsp_t;

  rsp_t        exp_q[$];
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  logic [3:0]      amo_ops  [9] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
  logic [XLEN-1:0] amo_wexp [9] = '{32'h80000008, 32'h80000018, 32'h80000018, 32'h00000000,
                                    32'h80000018, 32'h80000008, 32'h00000010, 32'h00000010,
                                    32'h80000008};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snoop(input logic [HW-1:0] h, input logic [XLEN-1:0] a);
    snoop_we_i   = 1'b1;
    snoop_hart_i = h;
    snoop_addr_i = a;
    step();
    snoop_we_i   = 1'b0;
  endtask

  // One request end to end; latency counted in cycles after the accept edge.
  task automatic do_op(input logic [HW-1:0] hart, input logic [3:0] op,
                       input logic [XLEN-1:0] addr, input logic [XLEN-1:0] rs2,
                       input logic [XLEN-1:0] rdata, input int unsigned dly,
                       input int unsigned exp_rd, input int unsigned exp_wr,
                       input logic [XLEN-1:0] exp_wdata, input logic [XLEN-1:0] exp_data,
                       input logic exp_err, input int unsigned exp_lat, input string tag);
    int unsigned     cyc, waited, n_rd, n_wr;
    bit              done;
    rsp_t            e;
    logic [XLEN-1:0] s_addr, s_wdata;
    logic            s_we;
    cyc = 0; waited = 0; n_rd = 0; n_wr = 0; done = 1'b0;
    s_addr = '0; s_wdata = '0; s_we = 1'b0;
    chk({tag, " ready"}, 32'(req_ready_o), 32'd1);
    e.data = exp_data;
    e.err  = exp_err;
    exp_q.push_back(e);
    req_valid_i = 1'b1;
    req_hart_i  = hart;
    req_op_i    = op;
    req_addr_i  = addr;
    req_rs2_i   = rs2;
    step();
    cyc = 1;
    req_valid_i = 1'b0;
    snoop_we_i  = 1'b0;
    while (!done && cyc <= 60) begin
      if (mem_req_o) begin
        if (waited == 0) begin
          s_addr = mem_addr_o; s_we = mem_we_o; s_wdata = mem_wdata_o;
        end else begin
          chk({tag, " stable addr"},  mem_addr_o, s_addr);
          chk({tag, " stable we"},    32'(mem_we_o), 32'(s_we));
          chk({tag, " stable wdata"}, mem_wdata_o, s_wdata);
          chk({tag, " busy ready"},   32'(req_ready_o), 32'd0);
        end
        if (waited == dly) begin
          waited      = 0;
          mem_ack_i   = 1'b1;
          mem_rdata_i = rdata;
          chk({tag, " mem addr"}, mem_addr_o, addr);
          if (mem_we_o) begin
            n_wr++;
            chk({tag, " wdata"}, mem_wdata_o, exp_wdata);
          end else begin
            n_rd++;
          end
        end else begin
          waited++;
        end
      end
      if (rsp_valid_o) begin
        done = 1'b1;
        chk({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        if (exp_q.size() == 0) begin
          chk({tag, " unexpected rsp"}, 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk({tag, " rsp data"}, rsp_data_o, e.data);
          chk({tag, " rsp err"},  32'(rsp_err_o), 32'(e.err));
        end
      end
      step();
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
      if (!done) cyc++;
    end
    if (!done) chk({tag, " rsp timeout"}, 32'd0, 32'd1);
    chk({tag, " reads"},     32'(n_rd), 32'(exp_rd));
    chk({tag, " writes"},    32'(n_wr), 32'(exp_wr));
    chk({tag, " rsp pulse"}, 32'(rsp_valid_o), 32'd0);
    chk({tag, " rsp idle"},  rsp_data_o, 32'd0);
  endtask

  initial begin
    int unsigned dly;
    rst = 1'b1;
    req_valid_i = 1'b0; req_hart_i = '0; req_op_i = '0; req_addr_i = '0; req_rs2_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    snoop_we_i = 1'b0; snoop_hart_i = '0; snoop_addr_i = '0;
    repeat (3) step();
    chk("reset ready",   32'(req_ready_o), 32'd0);
    chk("reset mem_req", 32'(mem_req_o),   32'd0);
    chk("reset rsp",     32'(rsp_valid_o), 32'd0);
    chk("reset data",    rsp_data_o,       32'd0);
    rst = 1'b0;
    step();
    chk("post reset ready", 32'(req_ready_o), 32'd1);

    // LR then SC pass, then repeat SC without LR
    do_op(0, 4'd0, 32'h1000, 32'h0, 32'h10, 0, 1, 0, 32'h0, 32'h10, 1'b0, 2, "t1_lr");
    do_op(0, 4'd1, 32'h1000, 32'hA5A5A5A5, 32'h0, 0, 0, 1, 32'hA5A5A5A5, 32'h0, 1'b0, 2, "t1_sc");
    do_op(0, 4'd1, 32'h1000, 32'h1234, 32'h0, 0, 0, 0, 32'h0, 32'h1, 1'b0, 1, "t2_sc");

    // Snoop from other hart (same granule) kills, own store does not
    do_op(0, 4'd0, 32'h1000, 32'h0, 32'h10, 0, 1, 0, 32'h0, 32'h10, 1'b0, 2, "t3_lr_a");
    snoop(1, 32'h1002);
    do_op(0, 4'd1, 32'h1000, 32'h1, 32'h0, 0, 0, 0, 32'h0, 32'h1, 1'b0, 1, "t3_sc_other");
    do_op(0, 4'd0, 32'h1000, 32'h0, 32'h10, 0, 1, 0, 32'h0, 32'h10, 1'b0, 2, "t3_lr_b");
    snoop(0, 32'h1000);
    do_op(0, 4'd1, 32'h1000, 32'h2, 32'h0, 0, 0, 1, 32'h2, 32'h0, 1'b0, 2, "t3_sc_own");
    do_op(0, 4'd0, 32'h1000, 32'h0, 32'h10, 0, 1, 0, 32'h0, 32'h10, 1'b0, 2, "t3_lr_c");
    snoop(1, 32'h1004);
    do_op(0, 4'd1, 32'h1000, 32'h3, 32'h0, 0, 0, 1, 32'h3, 32'h0, 1'b0, 2, "t3_sc_othergran");
    do_op(1, 4'd0, 32'h2000, 32'h0, 32'h7, 0, 1, 0, 32'h0, 32'h7, 1'b0, 2, "t3_lr_d");
    snoop_we_i = 1'b1; snoop_hart_i = 0; snoop_addr_i = 32'h2000;
    do_op(1, 4'd1, 32'h2000, 32'h4, 32'h0, 0, 0, 0, 32'h0, 32'h1, 1'b0, 1, "t3_sc_samecycle");
    do_op(0, 4'd0, 32'h1000, 32'h0, 32'h10, 0, 1, 0, 32'h0, 32'h10, 1'b0, 2, "t3_lr_e");
    do_op(0, 4'd1, 32'h1004, 32'h5, 32'h0, 0, 0, 0, 32'h0, 32'h1, 1'b0, 1, "t3_sc_wronggran");
    do_op(1, 4'd0, 32'h4000, 32'h0, 32'h5, 0, 1, 0, 32'h0, 32'h5, 1'b0, 2, "t3_lr_f");
    do_op(0, 4'd3, 32'h4000, 32'h1, 32'h5, 0, 1, 1, 32'h6, 32'h5, 1'b0, 3, "t3_amo_clear");
    do_op(1, 4'd1, 32'h4000, 32'h6, 32'h0, 0, 0, 0, 32'h0, 32'h1, 1'b0, 1, "t3_sc_after_amo");

    // AMO ops, old=0x10 rs2=0x80000008; ADD also exercises ack wait states
    for (int i = 0; i < 9; i++) begin
      dly = (amo_ops[i] == 4'd3) ? 2 : 0;
      do_op(1, amo_ops[i], 32'h5000, 32'h80000008, 32'h10, dly, 1, 1, amo_wexp[i],
            32'h10, 1'b0, 3 + 2 * dly, $sformatf("t4_op%0d", amo_ops[i]));
    end

    // Reservation lifetime edge
    do_op(0, 4'd0, 32'h6000, 32'h0, 32'h0, 0, 1, 0, 32'h0, 32'h0, 1'b0, 2, "t5_lr_a");
    repeat (TMO - 2) step();
    do_op(0, 4'd1, 32'h6000, 32'h9, 32'h0, 0, 0, 1, 32'h9, 32'h0, 1'b0, 2, "t5_sc_last");
    do_op(0, 4'd0, 32'h6000, 32'h0, 32'h0, 0, 1, 0, 32'h0, 32'h0, 1'b0, 2, "t5_lr_b");
    repeat (TMO - 1) step();
    do_op(0, 4'd1, 32'h6000, 32'h9, 32'h0, 0, 0, 0, 32'h0, 32'h1, 1'b0, 1, "t5_sc_expired");
    do_op(0, 4'd0, 32'h6000, 32'h0, 32'h0, 0, 1, 0, 32'h0, 32'h0, 1'b0, 2, "t5_lr_c");
    repeat (TMO - 3) step();
    do_op(0, 4'd0, 32'h6000, 32'h0, 32'h0, 0, 1, 0, 32'h0, 32'h0, 1'b0, 2, "t5_lr_renew");
    repeat (TMO - 2) step();
    do_op(0, 4'd1, 32'h6000, 32'hA, 32'h0, 0, 0, 1, 32'hA, 32'h0, 1'b0, 2, "t5_sc_renewed");

    // Slow memory, errors
    do_op(0, 4'd0, 32'h7000, 32'h0, 32'h77, 5, 1, 0, 32'h0, 32'h77, 1'b0, 7, "t6_lr_slow");
    do_op(0, 4'd0, 32'h1001, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1'b1, 1, "t6_misaligned");
    do_op(1, 4'd11, 32'h1000, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1'b1, 1, "t6_badop");

    // Reset while an SC write is outstanding
    do_op(1, 4'd0, 32'h9000, 32'h0, 32'h1, 0, 1, 0, 32'h0, 32'h1, 1'b0, 2, "t6_lr_h1");
    do_op(0, 4'd0, 32'h8000, 32'h0, 32'h2, 0, 1, 0, 32'h0, 32'h2, 1'b0, 2, "t6_lr_h0");
    chk("t6 rst ready", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_hart_i = 0; req_op_i = 4'd1;
    req_addr_i = 32'h8000; req_rs2_i = 32'h55;
    step();
    req_valid_i = 1'b0;
    chk("t6 wr mem_req", 32'(mem_req_o), 32'd1);
    chk("t6 wr we",      32'(mem_we_o),  32'd1);
    chk("t6 wr wdata",   mem_wdata_o,    32'h55);
    rst = 1'b1;
    step();
    chk("t6 rst mem_req", 32'(mem_req_o),   32'd0);
    chk("t6 rst rsp",     32'(rsp_valid_o), 32'd0);
    chk("t6 rst ready",   32'(req_ready_o), 32'd0);
    rst = 1'b0;
    step();
    chk("t6 post ready", 32'(req_ready_o), 32'd1);
    chk("t6 post rsp",   32'(rsp_valid_o), 32'd0);
    do_op(1, 4'd1, 32'h9000, 32'h3, 32'h0, 0, 0, 0, 32'h0, 32'h1, 1'b0, 1, "t6_sc_h1_after_rst");
    do_op(0, 4'd1, 32'h8000, 32'h3, 32'h0, 0, 0, 0, 32'h0, 32'h1, 1'b0, 1, "t6_sc_h0_after_rst");

    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
